// File: rtl/multi_path_clkdiv_pkg.sv
// Shared types and constants for the multi-path clock divider.
package multi_path_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OLD = 2'd1,
    WAIT_NEW = 2'd2
  } sel_state_e;

  // Every path comes out of reset dividing by DEFAULT_DIV+1.
  localparam int unsigned DEFAULT_DIV = 3;

endpackage

// File: rtl/multi_path_clkdiv_path.sv
// One divider path: wrap counter, pending ratio shadow and capture register.
module clkdiv_path
  import multi_path_clkdiv_pkg::*;
#(
  parameter int unsigned IDX    = 0,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              cfg_we_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              tick_o,
  output logic              pend_o,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [DATA_W-1:0] OFFSET  = DATA_W'(IDX);
  localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic              pend_q, pend_d, tick_q, tick_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wrap;

  always_comb begin
    wrap     = en_i && (cnt_q == div_q);
    cnt_d    = '0;
    tick_d   = wrap;
    data_d   = data_q;
    div_d    = div_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    if (en_i && !wrap) cnt_d = cnt_q + 1'b1;
    if (wrap) data_d = data_i + OFFSET;
    // A new ratio only takes effect between periods, or at once when idle.
    if (pend_q && (wrap || !en_i)) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end
    if (cfg_we_i) begin
      shadow_d = cfg_div_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      data_q   <= data_d;
    end
  end

  assign tick_o = tick_q;
  assign pend_o = pend_q;
  assign data_o = data_q;

endmodule

// File: rtl/multi_path_clkdiv.sv
// Multi-path clock divider with glitch-free ratio updates, XOR combiner
// and a select FSM that switches the observed path on period boundaries.
module multi_path_clkdiv
  import multi_path_clkdiv_pkg::*;
#(
  parameter  int unsigned NUM_PATHS = 4,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned DIV_W     = 4,
  localparam int unsigned PW        = $clog2(NUM_PATHS)
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic [NUM_PATHS-1:0]        path_en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [PW-1:0]               cfg_path,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [NUM_PATHS*DATA_W-1:0] data_in,
  input  logic                        sel_req,
  input  logic [PW-1:0]               sel_path,
  output logic                        sel_ack,
  output logic                        sel_err,
  output logic [NUM_PATHS-1:0]        path_tick,
  output logic [NUM_PATHS*DATA_W-1:0] path_data,
  output logic [DATA_W-1:0]           comb_data,
  output logic [DATA_W-1:0]           sel_data,
  output logic                        sel_valid,
  output logic [PW-1:0]               sel_cur,
  output sel_state_e                  dbg_sel_state
);

  // Index space padded to a power of two; phantom paths read as disabled,
  // never tick and never have a pending write.
  localparam int unsigned NP2 = 1 << PW;

  logic [NUM_PATHS-1:0] cfg_we, pend;
  logic [NP2-1:0]       tick_ext, en_ext, pend_ext;
  logic [DATA_W-1:0]    data_arr [NP2];
  logic [DATA_W-1:0]    xor_all;

  // cfg handshake: a write transfers on a clock edge where cfg_valid and
  // cfg_ready are both high; cfg_ready depends only on the addressed path.
  assign cfg_ready = !pend_ext[cfg_path];

  for (genvar i = 0; i < NUM_PATHS; i++) begin : g_path
    assign cfg_we[i] = cfg_valid && cfg_ready && (cfg_path == PW'(i));
    clkdiv_path #(
      .IDX    (i),
      .DATA_W (DATA_W),
      .DIV_W  (DIV_W)
    ) u_path (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en_i      (path_en[i]),
      .cfg_we_i  (cfg_we[i]),
      .cfg_div_i (cfg_div),
      .data_i    (data_in[i*DATA_W +: DATA_W]),
      .tick_o    (path_tick[i]),
      .pend_o    (pend[i]),
      .data_o    (path_data[i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    tick_ext = '0;
    en_ext   = '0;
    pend_ext = '0;
    tick_ext[NUM_PATHS-1:0] = path_tick;
    en_ext[NUM_PATHS-1:0]   = path_en;
    pend_ext[NUM_PATHS-1:0] = pend;
    xor_all = '0;
    for (int k = 0; k < NP2; k++) data_arr[k] = '0;
    for (int k = 0; k < NUM_PATHS; k++) begin
      data_arr[k] = path_data[k*DATA_W +: DATA_W];
      xor_all     = xor_all ^ path_data[k*DATA_W +: DATA_W];
    end
  end

  sel_state_e        state_q, state_d;
  logic [PW-1:0]     cur_q, cur_d, tgt_q, tgt_d;
  logic              ack_q, ack_d, err_q, err_d, svalid_q, svalid_d;
  logic [DATA_W-1:0] sdata_q, sdata_d, comb_q, comb_d;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    svalid_d = 1'b0;
    sdata_d  = sdata_q;
    comb_d   = (|path_tick) ? xor_all : comb_q;
    case (state_q)
      IDLE: begin
        if (sel_req && (sel_path == cur_q)) begin
          ack_d = 1'b1;
        end else if (sel_req && !en_ext[sel_path]) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (sel_req) begin
          tgt_d   = sel_path;
          state_d = WAIT_OLD;
        end
        // Suppressed on the switch edge so sel_valid never shows mid-switch.
        if (tick_ext[cur_q] && (state_d == IDLE)) begin
          sdata_d  = data_arr[cur_q];
          svalid_d = 1'b1;
        end
      end
      WAIT_OLD: begin
        if (!en_ext[cur_q] || tick_ext[cur_q]) state_d = WAIT_NEW;
      end
      WAIT_NEW: begin
        if (!en_ext[tgt_q]) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else if (tick_ext[tgt_q]) begin
          state_d = IDLE;
          cur_d   = tgt_q;
          ack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      tgt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      svalid_q <= 1'b0;
      sdata_q  <= '0;
      comb_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      svalid_q <= svalid_d;
      sdata_q  <= sdata_d;
      comb_q   <= comb_d;
    end
  end

  assign sel_ack       = ack_q;
  assign sel_err       = err_q;
  assign sel_valid     = svalid_q;
  assign sel_data      = sdata_q;
  assign sel_cur       = cur_q;
  assign comb_data     = comb_q;
  assign dbg_sel_state = state_q;

endmodule

// File: tb/tb_multi_path_clkdiv.sv
// Bench for multi_path_clkdiv: table vectors, randomized traffic against an
// edge-scheduling reference model, and hand-written select/reset sequences.
module tb_multi_path_clkdiv;
  import multi_path_clkdiv_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int PW = 2;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NP-1:0]    path_en;
  logic             cfg_valid, cfg_ready;
  logic [PW-1:0]    cfg_path;
  logic [VW-1:0]    cfg_div;
  logic [NP*DW-1:0] data_in;
  logic             sel_req, sel_ack, sel_err, sel_valid;
  logic [PW-1:0]    sel_path, sel_cur;
  logic [NP-1:0]    path_tick;
  logic [NP*DW-1:0] path_data;
  logic [DW-1:0]    comb_data, sel_data;
  sel_state_e       dbg_sel_state;

  multi_path_clkdiv #(.NUM_PATHS(NP), .DATA_W(DW), .DIV_W(VW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .path_en(path_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_path(cfg_path), .cfg_div(cfg_div),
    .data_in(data_in), .sel_req(sel_req), .sel_path(sel_path),
    .sel_ack(sel_ack), .sel_err(sel_err), .path_tick(path_tick), .path_data(path_data),
    .comb_data(comb_data), .sel_data(sel_data), .sel_valid(sel_valid), .sel_cur(sel_cur),
    .dbg_sel_state(dbg_sel_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each path is modelled by the absolute edge number of its next wrap.
  int            m_div[NP], m_shadow[NP], m_next[NP], m_e;
  bit            m_pend[NP];
  logic [DW-1:0] m_data[NP];
  logic [NP-1:0] m_tick;
  logic [DW-1:0] m_comb, m_sd;
  logic          m_sv;
  bit            chk_sel;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_div[i] = 3; m_shadow[i] = 0; m_pend[i] = 0; m_next[i] = 3; m_data[i] = '0;
    end
    m_tick = '0; m_comb = '0; m_sd = '0; m_sv = 1'b0; m_e = 0;
  endtask

  function automatic bit m_ready(input int p);
    return (p >= NP) ? 1'b1 : !m_pend[p];
  endfunction

  task automatic model_edge();
    int            acc;
    logic [DW-1:0] x;
    logic [NP-1:0] nt;
    acc = -1; x = '0; nt = '0;
    if (cfg_valid && m_ready(int'(cfg_path))) acc = int'(cfg_path);
    if (m_tick != '0) begin
      for (int i = 0; i < NP; i++) x ^= m_data[i];
      m_comb = x;
    end
    m_sv = m_tick[0];
    if (m_tick[0]) m_sd = m_data[0];
    for (int i = 0; i < NP; i++) begin
      if (path_en[i]) begin
        if (m_e == m_next[i]) begin
          m_data[i] = data_in[i*DW +: DW] + DW'(i);
          nt[i] = 1'b1;
          if (m_pend[i]) begin m_div[i] = m_shadow[i]; m_pend[i] = 0; end
          m_next[i] = m_e + 1 + m_div[i];
        end
      end else begin
        if (m_pend[i]) begin m_div[i] = m_shadow[i]; m_pend[i] = 0; end
        m_next[i] = m_e + 1 + m_div[i];
      end
      if (acc == i) begin m_shadow[i] = int'(cfg_div); m_pend[i] = 1; end
    end
    m_tick = nt;
    m_e++;
  endtask

  task automatic model_check();
    logic [NP*DW-1:0] pd;
    for (int i = 0; i < NP; i++) pd[i*DW +: DW] = m_data[i];
    chk("path_tick", path_tick, m_tick);
    chk("path_data", path_data, pd);
    chk("comb_data", comb_data, m_comb);
    chk("cfg_ready", cfg_ready, m_ready(int'(cfg_path)));
    if (chk_sel) begin
      chk("sel_valid", sel_valid, m_sv);
      chk("sel_data", sel_data, m_sd);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    model_check();
  endtask

  // Called at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0; sel_req = 1'b0; cfg_valid = 1'b0;
    #1;
    chk("rst_path_tick", path_tick, '0);
    chk("rst_path_data", path_data, '0);
    chk("rst_comb", comb_data, '0);
    chk("rst_sel_data", sel_data, '0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_ack", sel_ack, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_sel_cur", sel_cur, 0);
    chk("rst_state", dbg_sel_state, IDLE);
    chk("rst_cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_tick(input int p, input string name);
    int w = 0;
    while (!path_tick[p] && w < 20) begin cycle(); w++; end
    if (!path_tick[p]) chk(name, 0, 1);
  endtask

  task automatic wait_state(input sel_state_e s, input string name);
    int w = 0;
    while (dbg_sel_state != s && w < 20) begin cycle(); w++; end
    chk(name, dbg_sel_state, s);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [NP*DW-1:0] din;
    logic [NP*DW-1:0] pd;
    logic [DW-1:0]    comb;
  } vec_t;

  initial begin
    vec_t tbl[4];
    bit   exp_rdy[5];
    bit   exp_tk[5];
    int   t0, t2, ack_at;
    bit   sv_seen;

    tbl[0] = '{din: 32'h40302010, pd: 32'h43322110, comb: 8'h40};
    tbl[1] = '{din: 32'hFE0000FF, pd: 32'h010201FF, comb: 8'hFD};
    tbl[2] = '{din: 32'h00000000, pd: 32'h03020100, comb: 8'h00};
    tbl[3] = '{din: 32'hFFFFFFFF, pd: 32'h020100FF, comb: 8'hFC};
    exp_rdy = '{0, 0, 1, 1, 1};
    exp_tk  = '{0, 0, 1, 1, 1};

    path_en = '1; cfg_valid = 0; cfg_path = '0; cfg_div = '0;
    data_in = '0; sel_req = 0; sel_path = '0; chk_sel = 1;

    @(negedge clk_in);
    do_reset();

    // Default divide-by-4 on every path right after reset.
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("tick_period", path_tick, (k % 4 == 0) ? 4'hF : 4'h0);
    end

    // Capture and combine vectors.
    for (int v = 0; v < 4; v++) begin
      data_in = tbl[v].din;
      cycle();
      wait_tick(0, "tbl_tick_timeout");
      chk("tbl_path_data", path_data, tbl[v].pd);
      cycle();
      chk("tbl_comb", comb_data, tbl[v].comb);
    end

    // Ratio write mid-period: old period completes, then divide-by-1.
    wait_tick(1, "cfg_tick_timeout");
    cycle();
    cfg_valid = 1; cfg_path = 1; cfg_div = 0;
    chk("cfg_ready_idle", cfg_ready, 1);
    cycle();
    cfg_valid = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cycle();
      chk("cfg_apply_ready", cfg_ready, exp_rdy[k]);
      chk("cfg_apply_tick", path_tick[1], exp_tk[k]);
    end

    // Randomized traffic, no select requests.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) path_en = NP'($urandom_range(0, 15));
      data_in   = $urandom();
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_path  = PW'($urandom_range(0, NP - 1));
      cfg_div   = ($urandom_range(0, 7) == 0) ? 4'hF : VW'($urandom_range(0, 4));
      cycle();
    end
    cfg_valid = 0; path_en = '1;

    // Switch 0 -> 2 with path 2 at divide-by-2.
    chk_sel = 0;
    do_reset();
    cfg_valid = 1; cfg_path = 2; cfg_div = 1;
    cycle();
    cfg_valid = 0;
    for (int w = 0; w < 10 && !cfg_ready; w++) cycle();
    chk("cfg2_applied", cfg_ready, 1);
    sel_req = 1; sel_path = 2;
    cycle();
    sel_req = 0;
    t0 = -1; t2 = -1; ack_at = -1; sv_seen = 0;
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      if (sel_ack) ack_at = k;
      if (sel_valid) sv_seen = 1;
      if (t0 < 0 && path_tick[0]) t0 = k;
      else if (t0 >= 0 && t2 < 0 && path_tick[2]) t2 = k;
      if (ack_at < 0) cycle();
    end
    chk("sw_ack_cycle", ack_at, t2 + 1);
    chk("sw_no_valid", sv_seen, 0);
    chk("sw_err", sel_err, 0);
    chk("sw_cur", sel_cur, 2);
    chk("sw_state", dbg_sel_state, IDLE);
    wait_tick(2, "sw_newtick_timeout");
    cycle();
    chk("sel_valid_new", sel_valid, 1);
    chk("sel_data_new", sel_data, m_data[2]);

    // Select a disabled path, then the current path.
    path_en = 4'b0111;
    cycle();
    sel_req = 1; sel_path = 3;
    cycle();
    sel_req = 0;
    chk("dis_ack", sel_ack, 1);
    chk("dis_err", sel_err, 1);
    chk("dis_cur", sel_cur, 2);
    cycle();
    chk("dis_ack_pulse", sel_ack, 0);
    chk("dis_err_pulse", sel_err, 0);
    sel_req = 1; sel_path = 2;
    cycle();
    sel_req = 0;
    chk("same_ack", sel_ack, 1);
    chk("same_err", sel_err, 0);
    chk("same_state", dbg_sel_state, IDLE);
    path_en = '1;

    // Target disabled while in WAIT_NEW.
    do_reset();
    sel_req = 1; sel_path = 1;
    cycle();
    sel_req = 0;
    wait_state(WAIT_NEW, "tgtdis_reach");
    path_en[1] = 0;
    cycle();
    chk("tgtdis_ack", sel_ack, 1);
    chk("tgtdis_err", sel_err, 1);
    chk("tgtdis_cur", sel_cur, 0);
    chk("tgtdis_state", dbg_sel_state, IDLE);
    path_en = '1;
    cycle();

    // Old path disabled while in WAIT_OLD.
    sel_req = 1; sel_path = 2;
    cycle();
    sel_req = 0;
    chk("olddis_wait_old", dbg_sel_state, WAIT_OLD);
    path_en[0] = 0;
    cycle();
    chk("olddis_adv", dbg_sel_state, WAIT_NEW);
    for (int w = 0; w < 20 && !sel_ack; w++) cycle();
    chk("olddis_ack", sel_ack, 1);
    chk("olddis_cur", sel_cur, 2);
    path_en = '1;
    cycle();

    // Reset in the middle of a switch.
    sel_req = 1; sel_path = 1;
    cycle();
    sel_req = 0;
    wait_state(WAIT_NEW, "midrst_reach");
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("post_rst_tick", path_tick, (k % 4 == 0) ? 4'hF : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_path_clkdiv.md
MULTI_PATH_CLKDIV -- requirements
Module: multi_path_clkdiv

Interface
REQ-001 The block SHALL have parameter NUM_PATHS, default 4, giving the number of divider paths (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the per-path data width.
REQ-003 The block SHALL have parameter DIV_W, default 4, giving the width of the divide-ratio field.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port path_en, input, NUM_PATHS bits: per-path divider enable.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: divide-ratio write request.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: a write is accepted when cfg_valid and cfg_ready are both high.
REQ-009 The block SHALL have port cfg_path, input, PW = $clog2(NUM_PATHS) bits: target path of the write.
REQ-010 The block SHALL have port cfg_div, input, DIV_W bits: new ratio value D (the path divides by D+1).
REQ-011 The block SHALL have port data_in, input, NUM_PATHS*DATA_W bits: path i uses slice [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have the select ports: sel_req in 1, sel_path in PW, sel_ack out 1, sel_err out 1.
REQ-013 The block SHALL have port path_tick, output, NUM_PATHS bits: one-cycle pulse per path period.
REQ-014 The block SHALL have port path_data, output, NUM_PATHS*DATA_W bits: the path capture registers.
REQ-015 The block SHALL have the outputs comb_data (DATA_W), sel_data (DATA_W), sel_valid (1) and sel_cur (PW).

Function
REQ-016 Each path SHALL have a counter cnt_i that runs 0..div_i while path_en[i]=1 and holds at 0 while path_en[i]=0.
REQ-017 On the edge where cnt_i==div_i and the path is enabled, the path SHALL:
- load cnt_i <= 0;
- capture path_r_i <= data_in slice + i, mod 2^DATA_W;
- assert path_tick[i] for exactly the following cycle.
REQ-018 A path with div_i=0 SHALL tick every cycle, and a path with div_i=2^DIV_W-1 SHALL tick every 2^DIV_W cycles.
REQ-019 An accepted cfg write SHALL go to a pending shadow register and be applied at that path's next wrap edge, so no runt period occurs; for a disabled path it SHALL be applied on the next edge.
REQ-020 cfg_ready SHALL be 0 while the path addressed by cfg_path has a pending value, and 1 otherwise.
REQ-021 A write with cfg_path >= NUM_PATHS SHALL be accepted and discarded.
REQ-022 comb_data SHALL load the XOR of all path_r on the edge after any path_tick bit is high (one-cycle latency).
REQ-023 The select FSM SHALL use states IDLE, WAIT_OLD and WAIT_NEW:
- IDLE: sel_req with sel_path == sel_cur gives sel_ack the next cycle, with no state change.
- IDLE: sel_req to a disabled or out-of-range path gives sel_ack=1 and sel_err=1 for one cycle, with sel_cur unchanged.
- IDLE: any other sel_req latches the target and goes to WAIT_OLD.
- WAIT_OLD: stays until path_tick[sel_cur], then goes to WAIT_NEW.
- WAIT_NEW: stays until path_tick[target]; on that edge sel_cur <= target, sel_ack pulses for one cycle, and the FSM returns to IDLE.
REQ-024 sel_req SHALL be ignored outside IDLE.
REQ-025 If the old path is disabled during WAIT_OLD, the FSM SHALL advance immediately to WAIT_NEW.
REQ-026 If the target is disabled during WAIT_NEW, the FSM SHALL return to IDLE with an sel_ack and sel_err pulse.
REQ-027 In IDLE, sel_data SHALL load path_r[sel_cur] and sel_valid SHALL pulse on the edge after path_tick[sel_cur].
REQ-028 During WAIT_OLD and WAIT_NEW, sel_data SHALL hold and sel_valid SHALL stay 0.
REQ-029 A simultaneous tick on the old and target paths while in WAIT_OLD SHALL advance the FSM only to WAIT_NEW.

Reset
REQ-030 Asserting rst_n low SHALL clear the following at any time, including mid-switch:
- all cnt_i and path_r;
- all pending flags;
- path_tick, comb_data, sel_data, sel_valid, sel_ack, sel_err;
- sel_cur = 0, FSM = IDLE.
REQ-031 Reset SHALL set every div_i to 3 (divide-by-4), and cfg_ready SHALL be 1 after reset.

Structure
REQ-032 The FSM state enum and the default-ratio constant (3) SHALL be defined in package multi_path_clkdiv_pkg.
REQ-033 The per-path counter, shadow register and capture register SHALL be one sub-module, clkdiv_path, instantiated NUM_PATHS times in a generate loop; the select FSM and combine logic SHALL be top-level.

Verification
REQ-034 Reset release with all paths enabled and data_in = 0x40302010 -> each path_tick every 4 cycles; path_data = {0x43,0x32,0x21,0x10}, with path 0 in the LSB slice.
REQ-035 Write cfg_path=1, cfg_div=0 mid-period -> the current 4-cycle period completes, then path 1 ticks every cycle; cfg_ready is 0 for path 1 until the apply edge.
REQ-036 With paths 0 and 2 at different ratios, sel_req to path 2 -> sel_ack only after a path-0 tick followed by a path-2 tick; no sel_valid during the switch; sel_cur=2.
REQ-037 sel_req to a disabled path 3 -> sel_ack=1 and sel_err=1 for one cycle; sel_cur unchanged.
REQ-038 Assert rst_n while in WAIT_NEW -> all outputs are 0 and FSM=IDLE; after release, ticks resume at divide-by-4.
REQ-039 With data_in path 0 = 0xFF -> path_r0 = 0xFF; with data_in path 3 = 0xFE -> path_r3 = 0x01 (wrap); comb_data equals the XOR of all path_r.
